uart_boot_loader: RTL

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives 8N1 bytes, assembles little-endian words and writes IMEM then DMEM.
// Optional trailing checksum word is enabled with macro LOADER_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int BAUD_RATE    = 1000000,
  parameter int IMEM_ENTRIES = 4096,
  parameter int DMEM_ENTRIES = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rxd_i,
  output logic        imem_we_o,
  output logic        dmem_we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        done_o,
  output logic        frame_err_o,
  output logic        cksum_err_o
);

  localparam int          DIV       = CLK_FREQ_MHZ * 1000000 / BAUD_RATE;
  localparam int          HALF      = DIV / 2;
  localparam logic [31:0] DIV_LAST  = 32'(DIV - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF - 1);
  localparam logic [31:0] IMEM_LAST = 32'(IMEM_ENTRIES - 1);
  localparam logic [31:0] DMEM_LAST = 32'(DMEM_ENTRIES - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    LD_IMEM  = 2'd0,
    LD_DMEM  = 2'd1,
    LD_CKSUM = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;
`else
  typedef enum logic [1:0] {
    LD_IMEM  = 2'd0,
    LD_DMEM  = 2'd1,
    LD_DONE  = 2'd3
  } ld_state_e;
`endif

  logic        rxd_meta_q, rxd_sync_q;

  rx_state_e   rx_state_q, rx_state_d;
  logic [31:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_wait_q, stop_wait_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        frame_err_q, frame_err_d;

  ld_state_e   ld_state_q, ld_state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        imem_we_q, imem_we_d;
  logic        dmem_we_q, dmem_we_d;
  logic        done_q, done_d;
  logic [31:0] word_new_s;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        cksum_err_q, cksum_err_d;
`endif

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Receiver next-state: start-bit qualification at half period, then one sample per bit period
  always_comb begin
    rx_state_d  = rx_state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    stop_wait_d = stop_wait_q;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    frame_err_d = frame_err_q;
    case (rx_state_q)
      RX_IDLE: begin
        baud_cnt_d = 32'd0;
        if (!rxd_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = 32'd0;
          bit_cnt_d  = 3'd0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 32'd1;
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == DIV_LAST) begin
          baud_cnt_d = 32'd0;
          shift_d    = {rxd_sync_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          rx_state_d = (bit_cnt_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 32'd1;
        end
      end
      RX_STOP: begin
        // After a bad stop bit, hold here until the line returns idle
        if (stop_wait_q) begin
          if (rxd_sync_q) begin
            stop_wait_d = 1'b0;
            rx_state_d  = RX_IDLE;
          end else begin
            stop_wait_d = 1'b1;
          end
        end else if (baud_cnt_q == DIV_LAST) begin
          baud_cnt_d = 32'd0;
          if (rxd_sync_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            stop_wait_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 32'd1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Receiver state and byte-delivery registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q  <= RX_IDLE;
      baud_cnt_q  <= 32'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      stop_wait_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      stop_wait_q <= stop_wait_d;
      rx_valid_q  <= rx_valid_d;
      rx_byte_q   <= rx_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign word_new_s = {rx_byte_q, word_q[31:8]};

  // Loader next-state: word assembly, strobe generation and address/phase advance after each write
  always_comb begin
    ld_state_d = ld_state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    imem_we_d  = 1'b0;
    dmem_we_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    cksum_err_d = cksum_err_q;
`endif
    case (ld_state_q)
      LD_IMEM, LD_DMEM: begin
        if (rx_valid_q) begin
          word_d     = word_new_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wdata_d   = word_new_s;
            imem_we_d = (ld_state_q == LD_IMEM);
            dmem_we_d = (ld_state_q == LD_DMEM);
          end else begin
            wdata_d = wdata_q;
          end
        end else if (imem_we_q) begin
          if (waddr_q == IMEM_LAST) begin
            waddr_d    = 32'd0;
            ld_state_d = LD_DMEM;
          end else begin
            waddr_d = waddr_q + 32'd1;
          end
        end else if (dmem_we_q) begin
          waddr_d = waddr_q + 32'd1;
          if (waddr_q == DMEM_LAST) begin
`ifdef LOADER_CHECKSUM_EN
            ld_state_d = LD_CKSUM;
`else
            ld_state_d = LD_DONE;
`endif
          end else begin
            ld_state_d = ld_state_q;
          end
        end else begin
          word_d = word_q;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CKSUM: begin
        if (rx_valid_q) begin
          word_d     = word_new_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            cksum_err_d = cksum_err_q | (word_new_s != sum_q);
            ld_state_d  = LD_DONE;
          end else begin
            ld_state_d = LD_CKSUM;
          end
        end else begin
          word_d = word_q;
        end
      end
`endif
      LD_DONE: begin
        ld_state_d = LD_DONE;
      end
      default: begin
        ld_state_d = LD_IMEM;
      end
    endcase
`ifdef LOADER_CHECKSUM_EN
    if (imem_we_q || dmem_we_q) begin
      sum_d = sum_q + wdata_q;
    end else begin
      sum_d = sum_q;
    end
`endif
    done_d = (ld_state_d == LD_DONE);
  end

  // Loader state, write port and status registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_state_q <= LD_IMEM;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      waddr_q    <= 32'd0;
      wdata_q    <= 32'd0;
      imem_we_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      imem_we_q  <= imem_we_d;
      dmem_we_q  <= dmem_we_d;
      done_q     <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of written words and the checksum verdict
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q       <= 32'd0;
      cksum_err_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cksum_err_q <= cksum_err_d;
    end
  end

  assign cksum_err_o = cksum_err_q;
`else
  assign cksum_err_o = 1'b0;
`endif

  assign imem_we_o   = imem_we_q;
  assign dmem_we_o   = dmem_we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign done_o      = done_q;
  assign frame_err_o = frame_err_q;

endmodule
